// File: rtl/bram_dpm_arbiter.sv
// ---------------------------------------------------------------------------
// bram_dpm_arbiter
//   Shares one port of a 1-cycle-latency block RAM between two requesters.
//   Requests are taken only in IDLE. When both requesters ask at once, the
//   one that was not granted last wins. A granted requester gets a
//   fixed-length burst of len+1 beats with an auto-incrementing address that
//   wraps modulo 2^ADDR_W. There is always at least one IDLE cycle between
//   two bursts.
//
// Ports
//   clk, reset               system clock, synchronous active-high reset
//   reqN/weN/addrN/lenN      burst request, direction, start address and
//                            beat count minus one (N = 0, 1)
//   wdataN                   write data for the beat being acknowledged
//   ackN                     beat accepted this cycle
//   rvalidN                  rdata holds a read beat for requester N
//   doneN                    pulses together with the last ack of a burst
//   rdata                    shared read data, taken straight from bram_dout
//   bram_addr/din/wr/dout    RAM port pins
//   busy                     high while a burst is running
// ---------------------------------------------------------------------------
module bram_dpm_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [LEN_W-1:0]  len0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic              rvalid0,
    output logic              done0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [LEN_W-1:0]  len1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic              rvalid1,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    output logic              bram_wr,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              busy
);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_gnt;
    logic              r_last_gnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_cnt;
    logic              r_rvalid0;
    logic              r_rvalid1;

    logic              w_grant_valid;
    logic              w_grant_sel;
    logic              w_last_beat;

    assign w_last_beat = (r_cnt == '0);
    assign rdata       = bram_dout;
    assign rvalid0     = r_rvalid0;
    assign rvalid1     = r_rvalid1;

    always_comb begin
        w_state_next  = r_state;
        w_grant_valid = 1'b0;
        w_grant_sel   = 1'b0;
        ack0          = 1'b0;
        ack1          = 1'b0;
        done0         = 1'b0;
        done1         = 1'b0;
        bram_addr     = '0;
        bram_din      = '0;
        bram_wr       = 1'b0;
        busy          = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (req0 || req1) begin
                    w_grant_valid = 1'b1;
                    // Tie goes to whoever did not win last time; otherwise
                    // the lone requester wins.
                    w_grant_sel   = (req0 && req1) ? ~r_last_gnt : req1;
                    w_state_next  = S_BURST;
                end
            end
            S_BURST: begin
                busy      = 1'b1;
                bram_addr = r_addr;
                bram_din  = r_gnt ? wdata1 : wdata0;
                // Reset gates the strobes immediately so a burst cut short
                // by reset cannot write once more before the clearing edge.
                bram_wr   = r_we & ~reset;
                ack0      = ~r_gnt & ~reset;
                ack1      = r_gnt & ~reset;
                done0     = ack0 & w_last_beat;
                done1     = ack1 & w_last_beat;
                if (w_last_beat) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_gnt      <= 1'b0;
            r_last_gnt <= 1'b1;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            // RAM read data appears one cycle after its address, so the
            // valid strobe is simply the read-beat condition delayed once.
            r_rvalid0 <= (r_state == S_BURST) && !r_we && !r_gnt;
            r_rvalid1 <= (r_state == S_BURST) && !r_we &&  r_gnt;
            if (w_grant_valid) begin
                r_gnt  <= w_grant_sel;
                r_we   <= w_grant_sel ? we1   : we0;
                r_addr <= w_grant_sel ? addr1 : addr0;
                r_cnt  <= w_grant_sel ? len1  : len0;
            end else if (r_state == S_BURST) begin
                r_addr <= r_addr + 1'b1;
                r_cnt  <= r_cnt - 1'b1;
                if (w_last_beat) begin
                    r_last_gnt <= r_gnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_bram_dpm_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_dpm_arbiter
//   Directed bench for bram_dpm_arbiter. A behavioural 1K x 8 RAM with a
//   registered read sits on the RAM pins; ref_mem holds the contents the
//   bench intends the RAM to have. Inputs change on the falling edge and
//   outputs are sampled 1 time unit later. Status vectors compared each
//   cycle are {ack0, ack1, bram_wr, done0, done1, busy}.
// ---------------------------------------------------------------------------
module tb_bram_dpm_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0, we0, req1, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [LEN_W-1:0]  len0, len1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              ack0, rvalid0, done0, ack1, rvalid1, done1;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_din;
    logic              bram_wr;
    logic [DATA_W-1:0] bram_dout;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem     [0:1023];
    logic [7:0] ref_mem [0:1023];
    logic       mem_init;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'(i) ^ 8'h5A;
            bram_dout <= '0;
        end else begin
            if (bram_wr) mem[bram_addr] <= bram_din;
            bram_dout <= mem[bram_addr];
        end
    end

    bram_dpm_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .LEN_W (LEN_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0),
        .we0      (we0),
        .addr0    (addr0),
        .len0     (len0),
        .wdata0   (wdata0),
        .ack0     (ack0),
        .rvalid0  (rvalid0),
        .done0    (done0),
        .req1     (req1),
        .we1      (we1),
        .addr1    (addr1),
        .len1     (len1),
        .wdata1   (wdata1),
        .ack1     (ack1),
        .rvalid1  (rvalid1),
        .done1    (done1),
        .rdata    (rdata),
        .bram_addr(bram_addr),
        .bram_din (bram_din),
        .bram_wr  (bram_wr),
        .bram_dout(bram_dout),
        .busy     (busy)
    );

    task automatic test_reset();
        req0 = 0; we0 = 0; addr0 = '0; len0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; len1 = '0; wdata1 = '0;
        reset = 1; mem_init = 1;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
        repeat (3) @(negedge clk);
        reset = 0; mem_init = 0;
        #1;
        checks++;
        if ({ack0, ack1, bram_wr, done0, done1, busy, rvalid0, rvalid1} !== 8'b0)
            $display("FAIL reset_status got=%b exp=%b",
                     {ack0, ack1, bram_wr, done0, done1, busy, rvalid0, rvalid1}, 8'b0);
        checks++;
        if (bram_addr !== 10'h000 || bram_din !== 8'h00) begin
            failures++;
            $display("FAIL reset_bus addr=%h din=%h exp addr=000 din=00", bram_addr, bram_din);
        end
        if ({ack0, ack1, bram_wr, done0, done1, busy, rvalid0, rvalid1} !== 8'b0) failures++;
    endtask

    task automatic test_write_burst();
        logic [7:0] d [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        logic [5:0] exp_s;
        int nack = 0;
        @(negedge clk);
        req0 = 1; we0 = 1; addr0 = 10'h010; len0 = 4'd3; wdata0 = d[0];
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            wdata0 = (nack < 4) ? d[nack] : 8'h00;
            #1;
            exp_s = {c <= 4, 1'b0, c <= 4, c == 4, 1'b0, c <= 4};
            checks++;
            if ({ack0, ack1, bram_wr, done0, done1, busy} !== exp_s) begin
                failures++;
                $display("FAIL wr_status c=%0d got=%b exp=%b", c,
                         {ack0, ack1, bram_wr, done0, done1, busy}, exp_s);
            end
            if (c <= 4) begin
                checks++;
                if (bram_addr !== 10'(10'h010 + c - 1) || bram_din !== d[c-1]) begin
                    failures++;
                    $display("FAIL wr_bus c=%0d addr=%h din=%h exp addr=%h din=%h", c,
                             bram_addr, bram_din, 10'(10'h010 + c - 1), d[c-1]);
                end
                ref_mem[10'h010 + c - 1] = d[c-1];
            end
            if (ack0) nack++;
            if (c == 1) req0 = 0;
        end
        for (int a = 16'h010; a <= 16'h013; a++) begin
            checks++;
            if (mem[a] !== ref_mem[a]) begin
                failures++;
                $display("FAIL wr_mem addr=%h got=%h exp=%h", a, mem[a], ref_mem[a]);
            end
        end
    endtask

    task automatic test_read_burst();
        logic [5:0] exp_s;
        logic [1:0] exp_v;
        @(negedge clk);
        req1 = 1; we1 = 0; addr1 = 10'h010; len1 = 4'd3;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            #1;
            exp_s = {1'b0, c <= 4, 1'b0, 1'b0, c == 4, c <= 4};
            exp_v = {1'b0, c >= 2 && c <= 5};
            checks++;
            if ({ack0, ack1, bram_wr, done0, done1, busy} !== exp_s || {rvalid0, rvalid1} !== exp_v) begin
                failures++;
                $display("FAIL rd_status c=%0d got=%b/%b exp=%b/%b", c,
                         {ack0, ack1, bram_wr, done0, done1, busy}, {rvalid0, rvalid1}, exp_s, exp_v);
            end
            if (c >= 2 && c <= 5) begin
                checks++;
                if (rdata !== ref_mem[10'h010 + c - 2]) begin
                    failures++;
                    $display("FAIL rd_data c=%0d got=%h exp=%h", c, rdata, ref_mem[10'h010 + c - 2]);
                end
            end
            if (c == 1) req1 = 0;
        end
    endtask

    task automatic test_round_robin();
        logic [5:0] exp_s;
        logic [1:0] exp_v;
        @(negedge clk); reset = 1;
        @(negedge clk); reset = 0;
        req0 = 1; we0 = 0; addr0 = 10'h100; len0 = '0;
        req1 = 1; we1 = 0; addr1 = 10'h200; len1 = '0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            #1;
            exp_s = {c == 1 || c == 5, c == 3, 1'b0, c == 1 || c == 5, c == 3,
                     c == 1 || c == 3 || c == 5};
            exp_v = {c == 2 || c == 6, c == 4};
            checks++;
            if ({ack0, ack1, bram_wr, done0, done1, busy} !== exp_s || {rvalid0, rvalid1} !== exp_v) begin
                failures++;
                $display("FAIL rr_status c=%0d got=%b/%b exp=%b/%b", c,
                         {ack0, ack1, bram_wr, done0, done1, busy}, {rvalid0, rvalid1}, exp_s, exp_v);
            end
            if (c == 1 || c == 3 || c == 5) begin
                checks++;
                if (bram_addr !== ((c == 3) ? 10'h200 : 10'h100)) begin
                    failures++;
                    $display("FAIL rr_addr c=%0d got=%h exp=%h", c, bram_addr,
                             (c == 3) ? 10'h200 : 10'h100);
                end
            end
            if (c == 2 || c == 4 || c == 6) begin
                checks++;
                if (rdata !== ((c == 4) ? ref_mem[10'h200] : ref_mem[10'h100])) begin
                    failures++;
                    $display("FAIL rr_data c=%0d got=%h exp=%h", c, rdata,
                             (c == 4) ? ref_mem[10'h200] : ref_mem[10'h100]);
                end
            end
            if (c == 5) begin req0 = 0; req1 = 0; end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] d [4] = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
        logic [5:0] exp_s;
        logic [9:0] ea;
        int nack = 0;
        @(negedge clk);
        req1 = 1; we1 = 1; addr1 = 10'h3FE; len1 = 4'd3; wdata1 = d[0];
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            wdata1 = (nack < 4) ? d[nack] : 8'h00;
            #1;
            exp_s = {1'b0, c <= 4, c <= 4, 1'b0, c == 4, c <= 4};
            checks++;
            if ({ack0, ack1, bram_wr, done0, done1, busy} !== exp_s) begin
                failures++;
                $display("FAIL wrap_status c=%0d got=%b exp=%b", c,
                         {ack0, ack1, bram_wr, done0, done1, busy}, exp_s);
            end
            if (c <= 4) begin
                ea = 10'(10'h3FE + c - 1);
                checks++;
                if (bram_addr !== ea || bram_din !== d[c-1]) begin
                    failures++;
                    $display("FAIL wrap_bus c=%0d addr=%h din=%h exp addr=%h din=%h", c,
                             bram_addr, bram_din, ea, d[c-1]);
                end
                ref_mem[ea] = d[c-1];
            end
            if (ack1) nack++;
            if (c == 1) req1 = 0;
        end
        for (int k = 0; k < 4; k++) begin
            ea = 10'(10'h3FE + k);
            checks++;
            if (mem[ea] !== ref_mem[ea]) begin
                failures++;
                $display("FAIL wrap_mem addr=%h got=%h exp=%h", ea, mem[ea], ref_mem[ea]);
            end
        end
    endtask

    task automatic test_req_drop();
        logic [5:0] exp_s;
        logic [1:0] exp_v;
        logic [9:0] ea;
        @(negedge clk);
        req0 = 1; we0 = 0; addr0 = 10'h3F8; len0 = 4'd15;
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            #1;
            exp_s = {c <= 16, 1'b0, 1'b0, c == 16, 1'b0, c <= 16};
            exp_v = {c >= 2 && c <= 17, 1'b0};
            checks++;
            if ({ack0, ack1, bram_wr, done0, done1, busy} !== exp_s || {rvalid0, rvalid1} !== exp_v) begin
                failures++;
                $display("FAIL drop_status c=%0d got=%b/%b exp=%b/%b", c,
                         {ack0, ack1, bram_wr, done0, done1, busy}, {rvalid0, rvalid1}, exp_s, exp_v);
            end
            if (c >= 2 && c <= 17) begin
                ea = 10'(10'h3F8 + c - 2);
                checks++;
                if (rdata !== ref_mem[ea]) begin
                    failures++;
                    $display("FAIL drop_data c=%0d got=%h exp=%h", c, rdata, ref_mem[ea]);
                end
            end
            if (c == 1) req0 = 0;
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [7:0] d [8] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7};
        logic [5:0] exp_s;
        @(negedge clk);
        req0 = 1; we0 = 1; addr0 = 10'h080; len0 = 4'd7; wdata0 = d[0];
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            wdata0 = d[c-1];
            if (c == 3) reset = 1;
            #1;
            case (c)
                1, 2:    exp_s = 6'b101001;
                3:       exp_s = 6'b000001;
                default: exp_s = 6'b000000;
            endcase
            checks++;
            if ({ack0, ack1, bram_wr, done0, done1, busy} !== exp_s) begin
                failures++;
                $display("FAIL rst_status c=%0d got=%b exp=%b", c,
                         {ack0, ack1, bram_wr, done0, done1, busy}, exp_s);
            end
            if (c <= 2) ref_mem[10'h080 + c - 1] = d[c-1];
            if (c >= 4) begin
                checks++;
                if ({rvalid0, rvalid1} !== 2'b00) begin
                    failures++;
                    $display("FAIL rst_rvalid c=%0d got=%b exp=00", c, {rvalid0, rvalid1});
                end
            end
            if (c == 1) req0 = 0;
            if (c == 4) reset = 0;
        end
        for (int a = 16'h080; a <= 16'h087; a++) begin
            checks++;
            if (mem[a] !== ref_mem[a]) begin
                failures++;
                $display("FAIL rst_mem addr=%h got=%h exp=%h", a, mem[a], ref_mem[a]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_burst();
        test_round_robin();
        test_wrap();
        test_req_drop();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bram_dpm_arbiter.md
Name: bram_dpm_arbiter

Overview:
- Shares one port of the 1K x 8 dual-port block RAM between two requesters (requester 0 and requester 1).
- Uses round-robin arbitration and runs fixed-length bursts with auto-incrementing addresses.
- Sits between the RAM's A- or B-port pins (addr/datain/wr/dataout) and two client engines, such as a host register interface and a packet engine.
- The RAM has 1-cycle registered read latency; this block aligns read-data valid strobes to that latency.

Parameters:
ADDR_W, 10, RAM address width; addresses wrap modulo 2^ADDR_W.
DATA_W, 8, RAM data width.
LEN_W, 4, burst length field width; beats = len + 1 (1..16).

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
req0  input  1  requester 0 burst request; sampled only in IDLE.
we0  input  1  requester 0 direction: 1 = write, 0 = read.
addr0  input  ADDR_W  requester 0 burst start address.
len0  input  LEN_W  requester 0 beats minus one.
wdata0  input  DATA_W  requester 0 write data for the current beat.
ack0  output  1  requester 0 beat accepted this cycle.
rvalid0  output  1  rdata holds requester 0 read beat.
done0  output  1  one-cycle pulse on requester 0 last beat.
req1, we1, addr1, len1, wdata1, ack1, rvalid1, done1: same as above, for requester 1.
rdata  output  DATA_W  read data, driven from bram_dout and shared by both requesters.
bram_addr  output  ADDR_W  to RAM address port.
bram_din  output  DATA_W  to RAM data-in port.
bram_wr  output  1  to RAM write strobe.
bram_dout  input  DATA_W  from RAM data-out port.
busy  output  1  high while in BURST.

Behaviour:
- States: IDLE and BURST. Registers: gnt (1 bit), last_gnt, we_l, cur_addr, beat_cnt.
- Reset values:
  - state = IDLE, last_gnt = 1 (so requester 0 wins the first tie).
  - cur_addr = 0, beat_cnt = 0.
  - ack*, rvalid*, done*, busy, bram_wr = 0; bram_addr = 0, bram_din = 0.
- IDLE:
  - If exactly one req is high, grant that requester.
  - If both are high, grant the requester that is not last_gnt.
  - On grant, latch we_l, cur_addr = addrX and beat_cnt = lenX, then go to BURST on the next edge.
  - If no req is high, stay in IDLE.
- BURST, every cycle:
  - bram_addr = cur_addr and bram_wr = we_l (combinational from registers).
  - bram_din = wdata of the granted requester (combinational).
  - ack of the granted requester = 1; ack of the other requester = 0.
  - On the edge: cur_addr increments modulo 2^ADDR_W (1023 -> 0 at default width) and beat_cnt decrements.
- Last beat (beat_cnt == 0): done of the granted requester pulses in the same cycle as its ack. On the next edge, state goes to IDLE and last_gnt = gnt.
- Write handshake: the requester must present the beat's data on wdataX during its ack cycle and advance on ack.
- Read data: rvalidX is registered and set to (state == BURST && !we_l && gnt == X). rdata = bram_dout. This gives rvalid exactly 1 cycle after the matching ack.
- Latency:
  - req high in IDLE at edge N: first ack in cycle N+1.
  - First rvalid in cycle N+2.
  - A burst of B beats occupies B cycles, plus one mandatory IDLE cycle between bursts.
- req, we, addr and len are ignored during BURST. Dropping req mid-burst does not abort the burst; it completes all beats.
- A requester that holds req high after done re-arbitrates in IDLE. Round-robin gives the other requester priority if both requests are high.
- Reset during BURST:
  - bram_wr and ack* are forced to 0 combinationally while reset is high, so there are no further RAM writes.
  - All state clears at the edge; a partially completed burst is simply dropped.
  - rvalid* is 0 in the cycle after reset is sampled.
- busy = (state == BURST).
- The other RAM port is not touched. Coherence between ports is the system's responsibility.

Test Plan:
1. Write burst: req0 = 1, we0 = 1, addr0 = 0x010, len0 = 3, wdata = A0, A1, A2, A3 on successive acks -> bram_wr is high for 4 cycles at 0x010..0x013, and done0 pulses with the 4th ack.
2. Read burst: after test 1, req1 = 1, we1 = 0, addr1 = 0x010, len1 = 3 -> ack1 for 4 cycles, then rvalid1 for 4 cycles starting 1 cycle later with rdata = A0..A3, and rvalid0 never asserts.
3. Simultaneous requests from reset: req0 = req1 = 1, both len = 0 -> requester 0 is granted first, requester 1 second (after one IDLE cycle), then requester 0 again if both are still requesting.
4. Wrap-around: write burst at addr = 0x3FE, len = 3 -> bram_addr sequence is 0x3FE, 0x3FF, 0x000, 0x001.
5. Request dropped mid-burst: req0 deasserted after the first ack of a 16-beat read -> all 16 acks and 16 rvalids still occur, followed by done0.
6. Reset mid-burst: assert reset on the 3rd beat of an 8-beat write -> bram_wr is 0 from that cycle onward, busy = 0 after the edge, and the RAM contents beyond beat 2 are unchanged.
